// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC generation, single outstanding memory read and a
// QDEPTH-entry instruction queue toward decode. Define IF_BUBBLE_CNT_EN for BUBBLE_CNT.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | first cycle after reset, no fetch issued (memory settling)
// ST_RUN  | normal fetch/enqueue/dequeue operation until next reset
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_DATA,
  input  logic        IMEM_BUSYWAIT,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  input  logic        ID_READY,
  output logic        ID_VALID,
  output logic [31:0] ID_INSTR,
  output logic [31:0] ID_PC
`ifdef IF_BUBBLE_CNT_EN
  ,
  output logic [31:0] BUBBLE_CNT
`endif
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] LP_QDEPTH = (CW+1)'(QDEPTH);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t        r_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_pend_pc;
  logic          r_resp_pending;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [31:0]   r_q_instr [QDEPTH];
  logic [31:0]   r_q_pc    [QDEPTH];

  logic [CW:0]   w_occupancy;
  logic          w_issue;
  logic          w_enq;
  logic          w_deq;
  logic [31:0]   w_redirect_pc;

  // Credit counts the in-flight response so the queue can never overflow.
  assign w_occupancy   = {1'b0, r_count} + {{CW{1'b0}}, r_resp_pending};
  assign w_issue       = (r_state == ST_RUN) && !IMEM_BUSYWAIT && (w_occupancy < LP_QDEPTH);
  assign w_enq         = r_resp_pending && !REDIRECT;
  assign w_deq         = ID_VALID && ID_READY && !REDIRECT;
  assign w_redirect_pc = REDIRECT_PC & 32'hFFFF_FFFC;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state        <= ST_IDLE;
      r_fetch_pc     <= RESET_PC;
      r_pend_pc      <= 32'h0;
      r_resp_pending <= 1'b0;
      r_count        <= '0;
      r_rd_ptr       <= '0;
      r_wr_ptr       <= '0;
    end else if (REDIRECT) begin
      // In IDLE the queue is already empty, so only the PC effectively changes.
      r_state        <= ST_RUN;
      r_fetch_pc     <= w_redirect_pc;
      r_resp_pending <= 1'b0;
      r_count        <= '0;
      r_rd_ptr       <= '0;
      r_wr_ptr       <= '0;
    end else begin
      r_state        <= ST_RUN;
      r_resp_pending <= w_issue;
      if (w_issue) begin
        r_pend_pc  <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET && w_enq) begin
      r_q_instr[r_wr_ptr] <= IMEM_DATA;
      r_q_pc[r_wr_ptr]    <= r_pend_pc;
    end
  end

  assign IMEM_ADDR = r_fetch_pc;
  assign ID_VALID  = (r_count != '0);
  assign ID_INSTR  = ID_VALID ? r_q_instr[r_rd_ptr] : 32'h0;
  assign ID_PC     = ID_VALID ? r_q_pc[r_rd_ptr]    : 32'h0;

`ifdef IF_BUBBLE_CNT_EN
  logic [31:0] r_bubble_cnt;
  logic        w_bubble;

  assign w_bubble = (r_state == ST_RUN) && !ID_VALID && ID_READY;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_bubble_cnt <= 32'h0;
    end else if (w_bubble && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign BUBBLE_CNT = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          QDEPTH   = 4;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        busy;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
`ifdef IF_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt;
`endif

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Reference model state
  logic [31:0] mq_pc[$];
  logic [31:0] mq_instr[$];
  logic [31:0] m_fetch;
  logic [31:0] m_pend_pc;
  logic [31:0] m_bub;
  bit          m_pend;
  bit          m_run;

  if_fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .CLK(clk),
    .RESET(rst_b),
    .IMEM_ADDR(imem_addr),
    .IMEM_DATA(imem_data),
    .IMEM_BUSYWAIT(busy),
    .REDIRECT(redirect),
    .REDIRECT_PC(redirect_pc),
    .ID_READY(ready),
    .ID_VALID(id_valid),
    .ID_INSTR(id_instr),
    .ID_PC(id_pc)
`ifdef IF_BUBBLE_CNT_EN
    ,
    .BUBBLE_CNT(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0090_0093;
      32'h4:   return 32'h0050_0113;
      32'h8:   return 32'h0020_8333;
      default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endcase
  endfunction

  // Instruction memory: registered read, one cycle after the address.
  always @(posedge clk) imem_data <= mem_word(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, advanced on every rising edge from the pre-edge inputs.
  always @(posedge clk) begin
    bit issue;
    bit valid;
    if (!rst_b) begin
      mq_pc.delete();
      mq_instr.delete();
      m_fetch   = RESET_PC;
      m_pend    = 1'b0;
      m_pend_pc = 32'h0;
      m_run     = 1'b0;
      m_bub     = 32'h0;
    end else if (!m_run) begin
      m_run = 1'b1;
      if (redirect) m_fetch = {redirect_pc[31:2], 2'b00};
    end else begin
      valid = (mq_pc.size() != 0);
      if (!valid && ready && m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 1;
      if (redirect) begin
        mq_pc.delete();
        mq_instr.delete();
        m_pend  = 1'b0;
        m_fetch = {redirect_pc[31:2], 2'b00};
      end else begin
        issue = !busy && ((mq_pc.size() + int'(m_pend)) < QDEPTH);
        if (valid && ready) begin
          void'(mq_pc.pop_front());
          void'(mq_instr.pop_front());
        end
        if (m_pend) begin
          mq_pc.push_back(m_pend_pc);
          mq_instr.push_back(mem_word(m_pend_pc));
        end
        m_pend = issue;
        if (issue) begin
          m_pend_pc = m_fetch;
          m_fetch   = m_fetch + 32'd4;
        end
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      bit          e_valid;
      logic [31:0] e_instr;
      logic [31:0] e_pc;
      e_valid = (mq_pc.size() != 0);
      e_instr = e_valid ? mq_instr[0] : 32'h0;
      e_pc    = e_valid ? mq_pc[0]    : 32'h0;
      check("cyc_id_valid",  {31'h0, id_valid}, {31'h0, e_valid});
      check("cyc_id_instr",  id_instr,  e_instr);
      check("cyc_id_pc",     id_pc,     e_pc);
      check("cyc_imem_addr", imem_addr, m_fetch);
`ifdef IF_BUBBLE_CNT_EN
      check("cyc_bubble_cnt", bubble_cnt, m_bub);
`endif
      if (mq_pc.size() > QDEPTH) check("model_queue_bound", mq_pc.size(), QDEPTH);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] saved;
    rst_b = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; busy = 1'b0; ready = 1'b1;
    cyc();
    chk_en = 1'b1;
    cyc();
    check("rst_valid", {31'h0, id_valid}, 32'h0);
    check("rst_instr", id_instr, 32'h0);
    check("rst_pc",    id_pc,    32'h0);
    check("rst_addr",  imem_addr, RESET_PC);

    // Startup stream with ID_READY=1
    rst_b = 1'b1;
    cyc(); check("t1_addr_e0", imem_addr, 32'h0);
           check("t1_valid_e0", {31'h0, id_valid}, 32'h0);
    cyc(); check("t1_addr_e1", imem_addr, 32'h4);
           check("t1_valid_e1", {31'h0, id_valid}, 32'h0);
    cyc(); check("t1_valid_e2", {31'h0, id_valid}, 32'h1);
           check("t1_pc0", id_pc, 32'h0);
           check("t1_instr0", id_instr, 32'h0090_0093);
    cyc(); check("t1_pc4", id_pc, 32'h4);
           check("t1_instr4", id_instr, 32'h0050_0113);
    cyc(); check("t1_pc8", id_pc, 32'h8);
           check("t1_instr8", id_instr, 32'h0020_8333);
           check("t1_addr_e4", imem_addr, 32'h10);

    // Back-pressure: queue fills, fetch stops at 0x10
    rst_b = 1'b0; ready = 1'b0;
    cyc(); check("t2_rst_valid", {31'h0, id_valid}, 32'h0);
    rst_b = 1'b1;
    repeat (10) cyc();
    check("t2_addr_held", imem_addr, 32'h10);
    check("t2_head_pc0", id_pc, 32'h0);
    check("t2_valid", {31'h0, id_valid}, 32'h1);
    ready = 1'b1;
    cyc(); check("t2_pc4",  id_pc, 32'h4);
    cyc(); check("t2_pc8",  id_pc, 32'h8);
    cyc(); check("t2_pcc",  id_pc, 32'hC);
    cyc(); check("t2_pc10", id_pc, 32'h10);

    // Memory stall mid-stream
    repeat (3) cyc();
    busy = 1'b1;
    saved = m_fetch;
    repeat (3) begin
      cyc(); check("t3_addr_frozen", imem_addr, saved);
    end
    busy = 1'b0;
    repeat (6) cyc();

    // Redirect with 3 queued entries and one response in flight
    rst_b = 1'b0; ready = 1'b0;
    cyc();
    rst_b = 1'b1;
    repeat (5) cyc();
    redirect = 1'b1; redirect_pc = 32'h2E; ready = 1'b1;
    saved = m_bub;
    cyc(); redirect = 1'b0;
    check("t4_valid_er", {31'h0, id_valid}, 32'h0);
    check("t4_addr_er",  imem_addr, 32'h2C);
    cyc(); check("t4_valid_er1", {31'h0, id_valid}, 32'h0);
    cyc(); check("t4_valid_er2", {31'h0, id_valid}, 32'h1);
           check("t4_pc_er2", id_pc, 32'h2C);
           check("t4_instr_er2", id_instr, mem_word(32'h2C));
`ifdef IF_BUBBLE_CNT_EN
           check("t4_bubble_plus2", bubble_cnt, saved + 32'd2);
`endif

    // Reset with a full queue
    ready = 1'b0;
    repeat (8) cyc();
    check("t5_full_valid", {31'h0, id_valid}, 32'h1);
    rst_b = 1'b0;
    cyc(); check("t5_rst_valid", {31'h0, id_valid}, 32'h0);
           check("t5_rst_addr", imem_addr, RESET_PC);
    rst_b = 1'b1; ready = 1'b1;
    repeat (3) cyc();
    check("t5_restart_pc", id_pc, RESET_PC);
    check("t5_restart_valid", {31'h0, id_valid}, 32'h1);

    // Wrap of the fetch PC past 2^32
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFA;
    cyc(); redirect = 1'b0;
    check("t6_addr_wrap_start", imem_addr, 32'hFFFF_FFF8);
    repeat (2) cyc();
    check("t6_wrap_addr", imem_addr, 32'h0000_0000);

    // Randomized traffic
    repeat (3000) begin
      busy     = ($urandom_range(0, 3) == 0);
      ready    = ($urandom_range(0, 9) < 6);
      redirect = ($urandom_range(0, 29) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : 32'($urandom);
      rst_b    = ($urandom_range(0, 199) != 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of the instruction memory.
- Generates the fetch PC, drives the memory read address and captures the returned word, which the memory registers one cycle after the address.
- Buffers fetched instructions with their PCs in a small queue and hands them to decode over a valid/ready handshake.
- Accepts branch/jump redirects, which flush all queued and in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 00)
QDEPTH, 4, instruction queue entries; power of 2, minimum 2

Ports:
CLK  in  1  clock; all state updates on posedge
RESET  in  1  synchronous, active-low reset
IMEM_ADDR  out  32  read address to instruction memory
IMEM_DATA  in  32  read data; valid in the cycle after the address was presented
IMEM_BUSYWAIT  in  1  memory stall; no fetch is issued while high
REDIRECT  in  1  branch/jump taken; one-cycle pulse
REDIRECT_PC  in  32  redirect target; bits [1:0] ignored and treated as 00
ID_READY  in  1  decode accepts the head instruction
ID_VALID  out  1  head instruction valid
ID_INSTR  out  32  head instruction word
ID_PC  out  32  PC of head instruction

Behaviour:
Reset (RESET=0 at posedge):
- fetch_pc=RESET_PC; queue count, read pointer and write pointer=0; resp_pending=0; state=IDLE.
- Outputs after reset: ID_VALID=0, ID_INSTR=0, ID_PC=0, IMEM_ADDR=RESET_PC.
- Reset asserted mid-operation discards all queued and in-flight fetches with no partial writes.

State machine:
- IDLE: one cycle, no issue; gives memory time to initialise. Moves to RUN at the next posedge with RESET=1.
- RUN: normal operation. Leaves RUN only on reset.

Address output:
- IMEM_ADDR = fetch_pc at all times.

Issue (RUN only):
- Condition: IMEM_BUSYWAIT=0 and count + resp_pending < QDEPTH. Credit is computed from pre-edge values.
- On the edge ending an issue cycle: resp_pending<=1, pend_pc<=fetch_pc, fetch_pc<=fetch_pc+4. Wraps mod 2^32.
- Non-issue cycle: fetch_pc held and resp_pending<=0.

Response:
- If resp_pending=1, IMEM_DATA is written at that cycle's posedge as entry {IMEM_DATA, pend_pc} at the write pointer.
- IMEM_BUSYWAIT is not sampled in the response cycle.

Dequeue:
- Occurs when ID_VALID & ID_READY.
- Simultaneous enqueue and dequeue leave count unchanged.
- The credit rule guarantees the queue never overflows, so there is no full-drop path.

Output handshake:
- ID_VALID = (count != 0).
- ID_INSTR and ID_PC are the head entry, forced to 0 when count=0.
- Once ID_VALID=1, head data stays stable until accepted, flushed or reset.

Redirect (REDIRECT=1 at posedge):
- Priority over issue, enqueue and dequeue in that cycle.
- fetch_pc<={REDIRECT_PC[31:2],2'b00}; count and both pointers<=0; resp_pending<=0. The memory's stale response next cycle is discarded.
- Redirect during IDLE updates fetch_pc only.

Latency:
- Reset release: E0 = first posedge with RESET=1 (IDLE->RUN). Issue RESET_PC in the cycle after E0; ID_VALID=1 after E2.
- Redirect at edge Er: ID_VALID=1 after Er+2, provided BUSYWAIT=0.

Throughput:
- 1 instruction/cycle with ID_READY=1 and BUSYWAIT=0.
- With ID_READY=0, the queue fills to exactly QDEPTH and issue stops.
- Wraparound of QDEPTH-wide pointers is natural modulo.

Optional Feature:
Macro IF_BUBBLE_CNT_EN.
- Defined: adds output port BUBBLE_CNT (32 bits). It increments on every RUN-state cycle with ID_VALID=0 and ID_READY=1, saturates at 32'hFFFF_FFFF, resets to 0 and is not cleared by REDIRECT.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, RESET_PC=0, ID_READY=1, memory words 0x00900093, 0x00500113, 0x00208333 at 0/4/8 -> ID_VALID rises after E2; ID_PC 0, 4, 8 with matching ID_INSTR on consecutive cycles; IMEM_ADDR increments by 4 per cycle.
- ID_READY=0 for 10 cycles from reset, QDEPTH=4 -> count reaches 4, IMEM_ADDR held at 0x10, head stays PC 0. Release ID_READY -> PCs 0, 4, 8, 0xC, 0x10 delivered in order with no duplicates or gaps.
- IMEM_BUSYWAIT=1 for 3 cycles mid-stream -> IMEM_ADDR frozen 3 cycles; no duplicate entries; sequence resumes in order.
- REDIRECT with REDIRECT_PC=0x2E (bits [1:0] nonzero) while 3 entries are queued and one response is pending -> next ID_VALID is 2 edges later with ID_PC=0x2C; no pre-redirect PC ever appears.
- RESET=0 asserted for one edge mid-stream with a full queue -> ID_VALID=0 and IMEM_ADDR=RESET_PC on the next cycle; fetch restarts from RESET_PC.
- With IF_BUBBLE_CNT_EN: redirect with ID_READY=1 -> BUBBLE_CNT increases by exactly 2.
